// File: rtl/yin_pitch_picker_pkg.sv
// yin_pkg: shared state encoding, default widths and lag-word slicer
// for the YIN difference/picker stages.
package yin_pkg;

  localparam int DEF_INTERMEDIATE_DATA_WIDTH = 64;
  localparam int DEF_MAX_TAU                 = 40;
  localparam int DEF_TAU_BITS                = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEARCH,
    S_DESCEND,
    S_DONE
  } pick_state_e;

  // Word t of a packed lag vector, word t at [t*W +: W].
  function automatic logic [DEF_INTERMEDIATE_DATA_WIDTH-1:0] lag_word(
    input logic [DEF_MAX_TAU*DEF_INTERMEDIATE_DATA_WIDTH-1:0] vec,
    input logic [DEF_TAU_BITS-1:0]                            tau
  );
    return vec[int'(tau)*DEF_INTERMEDIATE_DATA_WIDTH +:
               DEF_INTERMEDIATE_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/yin_pitch_picker_if.sv
// yin_pitch_picker_if: frame request (start/results/threshold) and
// pitch result (ready/found/tau_out/min_value) bundle.
interface yin_pitch_picker_if
  import yin_pkg::*;
#(
  parameter int W        = DEF_INTERMEDIATE_DATA_WIDTH,
  parameter int MAX_TAU  = DEF_MAX_TAU,
  parameter int TAU_BITS = DEF_TAU_BITS
);
  logic                   start;
  logic [MAX_TAU*W-1:0]   results;
  logic [W-1:0]           threshold;
  logic                   ready;
  logic                   found;
  logic [TAU_BITS-1:0]    tau_out;
  logic [W-1:0]           min_value;

  modport master (
    output start, results, threshold,
    input  ready, found, tau_out, min_value
  );

  modport slave (
    input  start, results, threshold,
    output ready, found, tau_out, min_value
  );
endinterface

// File: rtl/yin_pitch_picker.sv
// yin_pitch_picker: latches a normalised-difference vector, finds the
// first lag under threshold, descends to the local minimum and reports it.
// Ports: clk, reset (async active-low), bus (yin_pitch_picker_if.slave).
// Build option: YIN_PICKER_GLOBAL_MIN_FALLBACK_EN reports the global
// minimum lag/value for unvoiced frames instead of zeros.
module yin_pitch_picker
  import yin_pkg::*;
#(
  parameter int INTERMEDIATE_DATA_WIDTH = DEF_INTERMEDIATE_DATA_WIDTH,
  parameter int MAX_TAU                 = DEF_MAX_TAU,
  parameter int TAU_BITS                = DEF_TAU_BITS,
  parameter int MIN_TAU                 = 2
) (
  input logic              clk,
  input logic              reset,
  yin_pitch_picker_if.slave bus
);

  localparam int W = INTERMEDIATE_DATA_WIDTH;
  localparam logic [TAU_BITS-1:0] FIRST = TAU_BITS'(MIN_TAU);
  localparam logic [TAU_BITS-1:0] LAST  = TAU_BITS'(MAX_TAU - 1);

  pick_state_e          state_q;
  logic [MAX_TAU*W-1:0] vec_q;
  logic [W-1:0]         thr_q;
  logic [TAU_BITS-1:0]  lag_q;
  logic                 voiced_q;
  logic                 ready_q;
  logic                 found_q;
  logic [TAU_BITS-1:0]  tau_q;
  logic [W-1:0]         min_q;
`ifdef YIN_PICKER_GLOBAL_MIN_FALLBACK_EN
  logic [W-1:0]         gmin_q;
  logic [TAU_BITS-1:0]  gtau_q;
`endif

  logic                at_end;
  logic [TAU_BITS-1:0] nxt_idx;
  logic [W-1:0]        cur_w;
  logic [W-1:0]        nxt_w;
  logic                hit;
  logic                desc;

  // nxt_idx never leaves the vector; at_end masks the compare anyway.
  assign at_end  = (lag_q == LAST);
  assign nxt_idx = at_end ? lag_q : lag_q + 1'b1;
  assign cur_w   = vec_q[int'(lag_q)*W +: W];
  assign nxt_w   = vec_q[int'(nxt_idx)*W +: W];
  assign hit     = (cur_w < thr_q);
  assign desc    = !at_end && (nxt_w < cur_w);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      thr_q    <= '0;
      lag_q    <= '0;
      voiced_q <= 1'b0;
      ready_q  <= 1'b0;
      found_q  <= 1'b0;
      tau_q    <= '0;
      min_q    <= '0;
`ifdef YIN_PICKER_GLOBAL_MIN_FALLBACK_EN
      gmin_q   <= '1;
      gtau_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            ready_q <= 1'b0;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          vec_q    <= bus.results;
          thr_q    <= bus.threshold;
          lag_q    <= FIRST;
          voiced_q <= 1'b0;
`ifdef YIN_PICKER_GLOBAL_MIN_FALLBACK_EN
          // All-ones start: a vector of all-ones words still
          // resolves to the first searched lag.
          gmin_q   <= '1;
          gtau_q   <= FIRST;
`endif
          state_q  <= S_SEARCH;
        end
        S_SEARCH: begin
          if (hit) begin
            voiced_q <= 1'b1;
            state_q  <= S_DESCEND;
          end else begin
`ifdef YIN_PICKER_GLOBAL_MIN_FALLBACK_EN
            if (cur_w < gmin_q) begin
              gmin_q <= cur_w;
              gtau_q <= lag_q;
            end
`endif
            if (at_end) state_q <= S_DONE;
            else        lag_q   <= lag_q + 1'b1;
          end
        end
        S_DESCEND: begin
          if (desc) lag_q   <= nxt_idx;
          else      state_q <= S_DONE;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          found_q <= voiced_q;
          if (voiced_q) begin
            tau_q <= lag_q;
            min_q <= cur_w;
          end else begin
`ifdef YIN_PICKER_GLOBAL_MIN_FALLBACK_EN
            tau_q <= gtau_q;
            min_q <= gmin_q;
`else
            tau_q <= '0;
            min_q <= '0;
`endif
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.found     = found_q;
  assign bus.tau_out   = tau_q;
  assign bus.min_value = min_q;

endmodule

// File: tb/tb_yin_pitch_picker.sv
// tb_yin_pitch_picker: directed frames with hand-computed pitch results,
// latency, robustness (start in SEARCH, reset in DESCEND) checks.
module tb_yin_pitch_picker;

  localparam int W  = 64;
  localparam int NT = 40;

  logic clk;
  logic reset;
  int   n_asrt;
  int   n_fail;
  int   lat;

  yin_pitch_picker_if bus ();

  yin_pitch_picker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [W-1:0] v);
    for (int t = 0; t < NT; t++) bus.results[t*W +: W] = v;
  endtask

  task automatic setw(input int t, input logic [W-1:0] v);
    bus.results[t*W +: W] = v;
  endtask

  // Accept start at edge 0, then count edges until ready is seen.
  // poke: pulse start and scramble results while the DUT is searching.
  task automatic run(input bit poke, output int l);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    l = 0;
    while (l < 100) begin
      @(posedge clk);
      #1;
      l++;
      if (poke && l == 3) begin
        bus.start = 1'b1;
        fill(64'd500);
      end
      if (poke && l == 4) bus.start = 1'b0;
      if (bus.ready) break;
    end
    if (l >= 100) begin
      n_asrt++;
      n_fail++;
      $error("FAIL timeout observed=%0d expected<100", l);
    end
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.threshold = 64'd100;
    fill(64'd500);
    #12;
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_found", 64'(bus.found), 64'd0);
    check("rst_tau", 64'(bus.tau_out), 64'd0);
    check("rst_min", bus.min_value, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Voiced: hit at 5, descend to 6.
    fill(64'd500);
    setw(5, 64'd80);
    setw(6, 64'd60);
    setw(7, 64'd70);
    run(1'b0, lat);
    check("v_lat", 64'(lat), 64'd8);
    check("v_found", 64'(bus.found), 64'd1);
    check("v_tau", 64'(bus.tau_out), 64'd6);
    check("v_min", bus.min_value, 64'd60);

    // Plateau: equal neighbour stops descent.
    fill(64'd500);
    setw(5, 64'd80);
    setw(6, 64'd80);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("accept_clr_ready", 64'(bus.ready), 64'd0);
    lat = 0;
    while (lat < 100 && !bus.ready) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("p_lat", 64'(lat), 64'd7);
    check("p_tau", 64'(bus.tau_out), 64'd5);
    check("p_min", bus.min_value, 64'd80);

    // Descent to the last lag.
    fill(64'd500);
    setw(37, 64'd90);
    setw(38, 64'd50);
    setw(39, 64'd10);
    run(1'b0, lat);
    check("e_lat", 64'(lat), 64'd41);
    check("e_found", 64'(bus.found), 64'd1);
    check("e_tau", 64'(bus.tau_out), 64'd39);
    check("e_min", bus.min_value, 64'd10);

    // Unvoiced with unique minimum at 12.
    fill(64'd500);
    setw(12, 64'd150);
    run(1'b0, lat);
    check("u_lat", 64'(lat), 64'd40);
    check("u_found", 64'(bus.found), 64'd0);
`ifdef YIN_PICKER_GLOBAL_MIN_FALLBACK_EN
    check("u_tau", 64'(bus.tau_out), 64'd12);
    check("u_min", bus.min_value, 64'd150);
`else
    check("u_tau", 64'(bus.tau_out), 64'd0);
    check("u_min", bus.min_value, 64'd0);
`endif

    // start in SEARCH ignored; results changed after capture.
    fill(64'd500);
    setw(5, 64'd80);
    setw(6, 64'd60);
    setw(7, 64'd70);
    run(1'b1, lat);
    check("s_lat", 64'(lat), 64'd8);
    check("s_found", 64'(bus.found), 64'd1);
    check("s_tau", 64'(bus.tau_out), 64'd6);
    repeat (3) @(posedge clk);
    #1;
    check("s_hold_ready", 64'(bus.ready), 64'd1);
    check("s_hold_tau", 64'(bus.tau_out), 64'd6);

    // Reset while descending (edge 6 is inside DESCEND).
    fill(64'd500);
    setw(5, 64'd80);
    setw(6, 64'd60);
    setw(7, 64'd70);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("r_ready", 64'(bus.ready), 64'd0);
    check("r_found", 64'(bus.found), 64'd0);
    check("r_tau", 64'(bus.tau_out), 64'd0);
    check("r_min", bus.min_value, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    fill(64'd500);
    setw(10, 64'd50);
    setw(11, 64'd40);
    run(1'b0, lat);
    check("r2_lat", 64'(lat), 64'd13);
    check("r2_found", 64'(bus.found), 64'd1);
    check("r2_tau", 64'(bus.tau_out), 64'd11);
    check("r2_min", bus.min_value, 64'd40);

    // Word 0 below threshold is never inspected.
    fill(64'd500);
    setw(0, 64'd0);
    run(1'b0, lat);
    check("z_lat", 64'(lat), 64'd40);
    check("z_found", 64'(bus.found), 64'd0);
`ifdef YIN_PICKER_GLOBAL_MIN_FALLBACK_EN
    check("z_tau", 64'(bus.tau_out), 64'd2);
    check("z_min", bus.min_value, 64'd500);
`else
    check("z_tau", 64'(bus.tau_out), 64'd0);
    check("z_min", bus.min_value, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/yin_pitch_picker.md
# yin_pitch_picker

Consumer of the cumulative-mean-normalised difference vector from the YIN difference stage. It latches the `MAX_TAU`-word result vector when a new frame is announced, then scans it one lag per cycle for the first lag below an absolute threshold. From that lag it descends to the local minimum and reports the pitch period (lag) with a valid/found indication. It sits directly after the normalised-difference stage and feeds the downstream frequency/note logic.

## Interface
- `INTERMEDIATE_DATA_WIDTH`, 64: width of each result word, threshold and reported minimum; unsigned fixed-point, same scaling as the producer.
- `MAX_TAU`, 40: number of words in `results`; valid lags 0..MAX_TAU−1.
- `TAU_BITS`, 6: width of the lag output; must satisfy 2**TAU_BITS ≥ MAX_TAU.
- `MIN_TAU`, 2: first lag searched. Lags below it are never inspected, and word 0 is never used. Range 1..MAX_TAU−1.
---
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (low) forces all state and outputs to reset values immediately.
- `start`  in  1  frame-available pulse; sampled only in IDLE.
- `results`  in  MAX_TAU*INTERMEDIATE_DATA_WIDTH  normalised-difference vector, word t at bits [t*W +: W]; must be stable on the cycle `start` is accepted.
- `threshold`  in  INTERMEDIATE_DATA_WIDTH  absolute threshold, latched with `results`.
- `ready`  out  1  result valid level.
- `found`  out  1  1 = threshold crossing found; 0 = unvoiced frame.
- `tau_out`  out  TAU_BITS  reported lag.
- `min_value`  out  INTERMEDIATE_DATA_WIDTH  `results` word at `tau_out`.

## Operation
- Reset values: `ready`=0, `found`=0, `tau_out`=0, `min_value`=0, state IDLE.
- States and transitions:
  - IDLE: `start`=1 → CAPTURE, and `ready` clears.
  - CAPTURE: copies `results` and `threshold` into internal registers, sets the lag counter to MIN_TAU, clears the global-minimum tracker → SEARCH.
  - SEARCH: compares word[lag] < threshold (strict, unsigned).
    - Hit → DESCEND, keeping the lag.
    - Miss: updates the global minimum (strictly smaller only, so the first occurrence wins ties), increments the lag.
    - Miss at lag = MAX_TAU−1 → DONE, unvoiced.
  - DESCEND: if lag < MAX_TAU−1 and word[lag+1] < word[lag] (strict), increments the lag. Otherwise → DONE, voiced. Equal neighbours stop the descent.
  - DONE: registers `found`, `tau_out`, `min_value`, sets `ready`=1 → IDLE.
- `ready` stays high, and the outputs hold, until the next accepted `start`.
- `start` outside IDLE is ignored, not queued.
- Reset asserted mid-frame aborts the frame: outputs return to reset values, state returns to IDLE.
- Arithmetic: comparisons only, no subtraction or division. Lag counter width is TAU_BITS.

## Timing
- Edge counts are from the edge that accepts `start`:
  - Voiced, final lag m: `ready` rises at edge +(m − MIN_TAU + 4).
  - Unvoiced: `ready` rises at edge +(MAX_TAU − MIN_TAU + 2).
- Throughput: one frame in flight. The next `start` is accepted the cycle after `ready` rises.
- `results` may change after CAPTURE; the block uses only its internal copy.

## Configuration
- `YIN_PICKER_GLOBAL_MIN_FALLBACK_EN` defined: an unvoiced frame reports `found`=0, `tau_out` = lag of the global minimum over MIN_TAU..MAX_TAU−1, and `min_value` = that word.
- Not defined: the global-minimum tracker is not built. Unvoiced frames report `found`=0, `tau_out`=0, `min_value`=0.
- Voiced behaviour and latency are identical in both builds.

## Structure
- Shared package `yin_pkg`:
  - state enumeration (IDLE, CAPTURE, SEARCH, DESCEND, DONE);
  - default widths: INTERMEDIATE_DATA_WIDTH, MAX_TAU, TAU_BITS;
  - the lag-word slicing helper also used by the producer stage.
- No sub-module: word selection is an indexed part-select on the captured vector, and the FSM is small enough to stay in one module.

## Test plan
- Voiced frame, threshold=100, MIN_TAU=2, MAX_TAU=40; words 2..4=500, word5=80, word6=60, word7=70, rest 500 → `found`=1, `tau_out`=6, `min_value`=60, `ready` at edge +8.
- Plateau stop: word5=80, word6=80 → `tau_out`=5; descent stops on equality.
- Descent to the end: words 37..39 = 90, 50, 10, all others 500, threshold=100 → `tau_out`=39, with no index past MAX_TAU−1.
- Unvoiced, all words ≥ threshold, word12=150 is the unique minimum, threshold=100:
  - with macro: `found`=0, `tau_out`=12, `min_value`=150;
  - without macro: all outputs 0;
  - `ready` at edge +40 in both builds.
- Robustness:
  - `start` pulsed during SEARCH is ignored; the result matches the first frame.
  - `reset` driven low during DESCEND → outputs 0 immediately, and a new frame then completes correctly.
- Word 0 = 0 with threshold=100, all others 500 → unvoiced; word 0 is never selected.
